transmitter: RTL and testbench
==============================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameters, one per line: CLKS_PER_BIT, default 868, clocks per UART bit (100 MHz / 115200); DATA_BITS, default 8, payload width; FIFO, default 4, TXBUF depth.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 btnC  input  1  load button; pushes the data switches into TXBUF.
REQ-006 btnD  input  1  send button; starts a transmission.
REQ-007 data  input  DATA_BITS  switch value to load.
REQ-008 stage4  input  1  0 = send newest entry only; 1 = send whole TXBUF.
REQ-009 tx  output  1  UART serial line, idle high.
REQ-010 done  output  DATA_BITS  last byte whose stop bit completed; drives LEDs.
REQ-011 TXBUF  output  FIFO x DATA_BITS  unpacked array [0:FIFO-1]; index FIFO-1 is newest.

Function
REQ-012 btnC and btnD each pass through a 2-flop synchronizer; action occurs on the synchronized rising edge, one pulse per press.
REQ-013 Load, idle only: TXBUF[i] <= TXBUF[i+1] for i < FIFO-1; TXBUF[FIFO-1] <= data; TXBUF[0] is discarded; no full/empty flags, shifting always succeeds.
REQ-014 btnC edges while a transmission is in progress are discarded, never queued.
REQ-015 Same-cycle btnC and btnD edges in IDLE: send wins, the load is discarded.
REQ-016 FSM states: IDLE, START, DATA, STOP; a btnD edge in IDLE enters START on the next clock.
REQ-017 stage4=0: one frame carrying TXBUF[FIFO-1].
REQ-018 stage4=1: FIFO frames carrying TXBUF[0], TXBUF[1], ... TXBUF[FIFO-1], in order.
REQ-019 In a stage4=1 burst, STOP goes directly to START of the next entry with no idle gap; after the last entry the FSM returns to IDLE.
REQ-020 stage4 is sampled only at the btnD edge; later changes do not affect the running burst.
REQ-021 Frame: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT clocks.
REQ-022 tx is registered, high in IDLE, and falls on the clock the FSM enters START.
REQ-023 The byte is latched at frame start; TXBUF cannot change mid-frame.
REQ-024 btnD edges during a transmission are ignored.
REQ-025 done updates to the sent byte on the last clock of each stop bit; in a burst it steps through every entry.
REQ-026 All-zero entries are transmitted normally; there is no empty check.

Reset
REQ-027 rst_n low asynchronously forces: tx=1; done=0; all TXBUF entries 0; FSM=IDLE; bit and baud counters 0; synchronizer and edge flops 0.
REQ-028 Reset mid-frame aborts immediately with tx high; after release, no frame resumes until a new btnD edge.

Configuration
REQ-029 Macro TRANSMITTER_DEBOUNCE_EN defined: each synchronized button must hold a new level for 2^16 consecutive clocks before edge detection sees it; shorter pulses are ignored.
REQ-030 Macro TRANSMITTER_DEBOUNCE_EN undefined: synchronized buttons feed edge detection directly and one clock-wide synchronized pulse suffices.

Verification
REQ-031 Benches run with CLKS_PER_BIT=4, DATA_BITS=8, FIFO=4, and debounce disabled unless stated.
REQ-032 Reset, then load 0x11, 0x22, 0x33, 0xA5 -> TXBUF = {0x11,0x22,0x33,0xA5}; a fifth load of 0x5A -> {0x22,0x33,0xA5,0x5A}.
REQ-033 TXBUF newest = 0xA5, stage4=0, press btnD -> tx low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, high 4 clocks; done=0xA5; 40 clocks total.
REQ-034 stage4=1, TXBUF {0x11,0x22,0x33,0xA5}, press btnD -> four back-to-back frames (160 clocks, no idle gap); done shows 0x11, 0x22, 0x33, 0xA5 in turn.
REQ-035 Press btnC (data=0xFF) and btnD during a frame -> TXBUF unchanged, no extra frame.
REQ-036 Assert rst_n low at clock 10 of a frame -> tx=1, TXBUF all 0 and done=0 at once; no tx activity until the next btnD edge.
REQ-037 TRANSMITTER_DEBOUNCE_EN defined: a 1000-clock btnC pulse -> no load; a 70000-clock btnC pulse -> exactly one load.

Source files
------------

// File: rtl/transmitter.sv
// UART transmitter with a shift-register TXBUF loaded from switches; sends the newest entry or the whole buffer.
// Optional button debounce is enabled by defining TRANSMITTER_DEBOUNCE_EN.
module transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btnC,
  input  logic                 btnD,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 stage4,
  output logic                 tx,
  output logic [DATA_BITS-1:0] done,
  output logic [DATA_BITS-1:0] TXBUF [0:FIFO-1]
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int IW = (FIFO > 1) ? $clog2(FIFO) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [BW-1:0]        baud;
  logic [NW-1:0]        bit_cnt;
  logic [IW-1:0]        idx;
  logic                 burst;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] cur;

  logic [1:0] c_sync, d_sync;
  logic       c_lvl, d_lvl, c_prev, d_prev;
  logic       c_rise, d_rise;
  logic       bit_end;
  logic [IW-1:0] nxt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync <= '0;
      d_sync <= '0;
      c_prev <= 1'b0;
      d_prev <= 1'b0;
    end else begin
      c_sync <= {c_sync[0], btnC};
      d_sync <= {d_sync[0], btnD};
      c_prev <= c_lvl;
      d_prev <= d_lvl;
    end
  end

`ifdef TRANSMITTER_DEBOUNCE_EN
  logic [15:0] c_cnt, d_cnt;

  // A level is accepted only after 2^16 consecutive clocks of disagreement with the held level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_cnt <= '0;
      d_cnt <= '0;
      c_lvl <= 1'b0;
      d_lvl <= 1'b0;
    end else begin
      if (c_sync[1] == c_lvl) c_cnt <= '0;
      else if (c_cnt == '1) begin
        c_lvl <= c_sync[1];
        c_cnt <= '0;
      end else c_cnt <= c_cnt + 16'd1;
      if (d_sync[1] == d_lvl) d_cnt <= '0;
      else if (d_cnt == '1) begin
        d_lvl <= d_sync[1];
        d_cnt <= '0;
      end else d_cnt <= d_cnt + 16'd1;
    end
  end
`else
  always_comb begin
    c_lvl = c_sync[1];
    d_lvl = d_sync[1];
  end
`endif

  always_comb begin
    c_rise  = c_lvl & ~c_prev;
    d_rise  = d_lvl & ~d_prev;
    bit_end = (baud == BW'(CLKS_PER_BIT - 1));
    nxt_idx = idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      done    <= '0;
      baud    <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      burst   <= 1'b0;
      shift   <= '0;
      cur     <= '0;
      for (int unsigned i = 0; i < FIFO; i++) TXBUF[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          baud <= '0;
          if (d_rise) begin
            state <= START;
            tx    <= 1'b0;
            burst <= stage4;
            idx   <= '0;
            shift <= stage4 ? TXBUF[0] : TXBUF[FIFO-1];
            cur   <= stage4 ? TXBUF[0] : TXBUF[FIFO-1];
          end else if (c_rise) begin
            for (int unsigned i = 0; i < FIFO - 1; i++) TXBUF[i] <= TXBUF[i+1];
            TXBUF[FIFO-1] <= data;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
            shift   <= shift >> 1;
          end else baud <= baud + BW'(1);
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_cnt == NW'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + NW'(1);
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else baud <= baud + BW'(1);
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            done <= cur;
            // Burst chains straight into the next start bit with no idle clock.
            if (burst && idx != IW'(FIFO - 1)) begin
              state <= START;
              tx    <= 1'b0;
              idx   <= nxt_idx;
              shift <= TXBUF[nxt_idx];
              cur   <= TXBUF[nxt_idx];
            end else state <= IDLE;
          end else baud <= baud + BW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: loads, single and burst frames, ignored presses, mid-frame reset, debounce.
module tb_transmitter;
  logic       clk;
  logic       rst_n;
  logic       btnC;
  logic       btnD;
  logic [7:0] data;
  logic       stage4;
  logic       tx;
  logic [7:0] done;
  logic [7:0] txbuf [0:3];

  int total = 0;
  int bad   = 0;

  transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btnC   (btnC),
    .btnD   (btnD),
    .data   (data),
    .stage4 (stage4),
    .tx     (tx),
    .done   (done),
    .TXBUF  (txbuf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_buf(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    check_eq({tag, "[0]"}, {24'd0, txbuf[0]}, {24'd0, e0});
    check_eq({tag, "[1]"}, {24'd0, txbuf[1]}, {24'd0, e1});
    check_eq({tag, "[2]"}, {24'd0, txbuf[2]}, {24'd0, e2});
    check_eq({tag, "[3]"}, {24'd0, txbuf[3]}, {24'd0, e3});
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    data = v;
    btnC = 1'b1;
    @(negedge clk);
    btnC = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input logic s);
    @(negedge clk);
    stage4 = s;
    btnD   = 1'b1;
    @(negedge clk);
    btnD = 1'b0;
  endtask

  // Returns at the negedge where tx is first seen low (first clock of the start bit).
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) check_eq({tag, "_start_timeout"}, 32'd1, 32'd0);
  endtask

  // Samples each bit mid-way; leaves at the middle of the stop bit (38 clocks after start).
  task automatic recv_frame(input string tag, output logic [7:0] b);
    wait_start(tag);
    repeat (2) @(negedge clk);
    check_eq({tag, "_startbit"}, {31'd0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx;
    end
    repeat (4) @(negedge clk);
    check_eq({tag, "_stopbit"}, {31'd0, tx}, 32'd1);
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp_b [0:3];
    int lows;
    rst_n  = 1'b0;
    btnC   = 1'b0;
    btnD   = 1'b0;
    data   = 8'h00;
    stage4 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_done", {24'd0, done}, 32'd0);
    check_buf("rst_buf", 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef TRANSMITTER_DEBOUNCE_EN
    @(negedge clk);
    data = 8'h99;
    btnC = 1'b1;
    repeat (1000) @(negedge clk);
    btnC = 1'b0;
    repeat (20) @(negedge clk);
    check_buf("db_short", 8'h00, 8'h00, 8'h00, 8'h00);
    data = 8'h77;
    btnC = 1'b1;
    repeat (70000) @(negedge clk);
    btnC = 1'b0;
    repeat (20) @(negedge clk);
    check_buf("db_long", 8'h00, 8'h00, 8'h00, 8'h77);
    check_eq("db_tx_idle", {31'd0, tx}, 32'd1);
`else
    load(8'h11);
    load(8'h22);
    load(8'h33);
    load(8'hA5);
    check_buf("load4", 8'h11, 8'h22, 8'h33, 8'hA5);

    send(1'b0);
    recv_frame("single", b);
    check_eq("single_byte", {24'd0, b}, 32'hA5);
    repeat (2) @(negedge clk);
    check_eq("single_done", {24'd0, done}, 32'hA5);
    check_eq("single_end_idle", {31'd0, tx}, 32'd1);
    count_low(30, lows);
    check_eq("single_no_extra", lows, 32'd0);

    exp_b[0] = 8'h11;
    exp_b[1] = 8'h22;
    exp_b[2] = 8'h33;
    exp_b[3] = 8'hA5;
    send(1'b1);
    for (int f = 0; f < 4; f++) begin
      recv_frame($sformatf("burst%0d", f), b);
      if (f == 0) stage4 = 1'b0;
      check_eq($sformatf("burst%0d_byte", f), {24'd0, b}, {24'd0, exp_b[f]});
      repeat (2) @(negedge clk);
      check_eq($sformatf("burst%0d_done", f), {24'd0, done}, {24'd0, exp_b[f]});
      check_eq($sformatf("burst%0d_nextbit", f), {31'd0, tx}, (f < 3) ? 32'd0 : 32'd1);
    end
    count_low(30, lows);
    check_eq("burst_no_extra", lows, 32'd0);

    send(1'b0);
    wait_start("busy");
    repeat (8) @(negedge clk);
    data = 8'hFF;
    btnC = 1'b1;
    btnD = 1'b1;
    repeat (2) @(negedge clk);
    btnC = 1'b0;
    btnD = 1'b0;
    data = 8'h00;
    repeat (30) @(negedge clk);
    check_eq("busy_done", {24'd0, done}, 32'hA5);
    check_buf("busy_buf", 8'h11, 8'h22, 8'h33, 8'hA5);
    count_low(100, lows);
    check_eq("busy_no_extra", lows, 32'd0);

    load(8'h5A);
    check_buf("load5", 8'h22, 8'h33, 8'hA5, 8'h5A);

    send(1'b0);
    wait_start("rst_mid");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_tx", {31'd0, tx}, 32'd1);
    check_eq("rstmid_done", {24'd0, done}, 32'd0);
    check_buf("rstmid_buf", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    count_low(100, lows);
    check_eq("rstmid_quiet", lows, 32'd0);

    send(1'b0);
    recv_frame("zero", b);
    check_eq("zero_byte", {24'd0, b}, 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
